// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the time-multiplexed FIR tap sequencer.
//   - state_t      : sequencer FSM states
//   - DEF_*        : default tap count, data width and output shift
//   - sat_to_width : clamp a signed value to the range of a w-bit signed word
package fir_ctrl_pkg;

    localparam int DEF_NTAPS = 129;
    localparam int DEF_DW    = 16;
    localparam int DEF_SHIFT = 15;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_OUT
    } state_t;

    // Clamp v to [-2^(w-1), 2^(w-1)-1]; the caller truncates the result to w bits.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_acc.sv
// Registered signed multiply-accumulate.
//   clk, reset : clock, asynchronous active-high reset (accumulator -> 0)
//   en         : update the accumulator this cycle
//   load       : with en, replace the accumulator by the product instead of adding
//   a, b       : signed DW-bit operands
//   acc_next   : value the accumulator takes at the next edge when en is high;
//                exposed so the final sum can be captured on the same edge it
//                is formed
module fir_mac_acc #(
    parameter int DW   = 16,
    parameter int ACCW = 40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc_next
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    always_comb begin
        prod     = $signed(a) * $signed(b);
        prod_ext = ACCW'(prod);
        sum      = load ? prod_ext : acc_q + prod_ext;
        acc_d    = en ? sum : acc_q;
        acc_next = sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequencer that walks all taps of an FIR through a single MAC.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : input sample handshake, in_data sample
//   smp_we/waddr/wdata    : circular sample RAM write port
//   smp_raddr/smp_rdata   : sample RAM read port (1-cycle read latency)
//   coef_raddr/coef_rdata : coefficient ROM port (1-cycle read latency)
//   out_valid/out_ready   : result handshake, out_data saturated result
//   busy                  : high in every state except IDLE
module fir_tap_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int DW    = DEF_DW,
    parameter int SHIFT = DEF_SHIFT,
    localparam int AW   = $clog2(NTAPS),
    localparam int ACCW = 2 * DW + AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          smp_we,
    output logic [AW-1:0] smp_waddr,
    output logic [DW-1:0] smp_wdata,
    output logic [AW-1:0] smp_raddr,
    input  logic [DW-1:0] smp_rdata,
    output logic [AW-1:0] coef_raddr,
    input  logic [DW-1:0] coef_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] tap_q, tap_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          mac_en_q, mac_en_d;
    logic          mac_load_q, mac_load_d;

    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] acc_shifted;

    fir_mac_acc #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en       (mac_en_q),
        .load     (mac_load_q),
        .a        (smp_rdata),
        .b        (coef_rdata),
        .acc_next (acc_next)
    );

    // Newest sample sits at base; tap k reads base-k, folded back into [0, NTAPS-1].
    // The fold is done modulo 2^AW, which is exact because the true result is < NTAPS.
    always_comb begin
        if (base_q >= tap_q) begin
            smp_raddr = base_q - tap_q;
        end else begin
            smp_raddr = base_q - tap_q + AW'(NTAPS);
        end
        coef_raddr  = tap_q;
        acc_shifted = acc_next >>> SHIFT;
    end

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        base_d     = base_q;
        wptr_d     = wptr_q;
        out_data_d = out_data_q;
        mac_en_d   = 1'b0;
        mac_load_d = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        smp_we     = 1'b0;
        smp_waddr  = '0;
        smp_wdata  = '0;

        unique case (state_q)
            ST_CLEAR: begin
                // The tap counter doubles as the clear address. The write is
                // held off while reset is asserted so the RAM is only cleared
                // once reset has been released.
                smp_we    = ~reset;
                smp_waddr = tap_q;
                if (tap_q == LAST) begin
                    tap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tap_d = tap_q + AW'(1);
                end
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    smp_we    = 1'b1;
                    smp_waddr = wptr_q;
                    smp_wdata = in_data;
                    base_d    = wptr_q;
                    tap_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Read data returns one cycle later, so the MAC controls are
                // this cycle's issue strobe delayed by one register stage.
                mac_en_d   = 1'b1;
                mac_load_d = (tap_q == '0);
                if (tap_q == LAST) begin
                    tap_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    tap_d = tap_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                // The last product is added on this edge; capture the finished
                // sum straight from the MAC adder so out_data is ready in OUT.
                out_data_d = DW'(sat_to_width(64'(acc_shifted), DW));
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            tap_q      <= '0;
            base_q     <= '0;
            wptr_q     <= '0;
            out_data_q <= '0;
            mac_en_q   <= 1'b0;
            mac_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            base_q     <= base_d;
            wptr_q     <= wptr_d;
            out_data_q <= out_data_d;
            mac_en_q   <= mac_en_d;
            mac_load_q <= mac_load_d;
        end
    end

    assign out_data = out_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
